// File: rtl/distribution_store_unit_pkg.sv
// Shared definitions for the distribution store unit: FSM encoding, SPI opcode,
// frame geometry and the frame-assembly helper.
package distribution_store_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } ds_state_e;

    localparam int         FRAME_BITS = 288;
    localparam int         ADDR_BITS  = 24;
    localparam int         DATA_BITS  = 256;
    localparam logic [7:0] DS_OPCODE  = 8'h02;

    // Frame layout on the wire, MSB first: opcode, 24-bit address, payload.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic [ADDR_BITS-1:0] addr,
        input logic [DATA_BITS-1:0] data
    );
        return {DS_OPCODE, addr, data};
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI mode-0 clock divider: each SCLK phase lasts HALF_PERIOD clk cycles.
// hold_i keeps SCLK low while still timing half periods (used for CS setup).
module spi_sclk_gen #(
    parameter int unsigned HALF_PERIOD = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic hold_i,
    output logic sclk_o,
    output logic half_tick_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [7:0] LAST_COUNT = 8'(HALF_PERIOD - 1);

    logic [7:0] count_q, count_d;
    logic       sclk_q, sclk_d;

    // NOTE: every output of this always_comb gets a default first, so no latch is inferred.
    always_comb begin
        count_d     = count_q;
        sclk_d      = sclk_q;
        half_tick_o = en_i && (count_q == LAST_COUNT);
        rise_o      = half_tick_o && !hold_i && !sclk_q;
        fall_o      = half_tick_o && !hold_i && sclk_q;

        if (!en_i) begin
            count_d = '0;
            sclk_d  = 1'b0;
        end else if (half_tick_o) begin
            count_d = '0;
            if (!hold_i) begin
                sclk_d = ~sclk_q;
            end
        end else begin
            count_d = count_q + 8'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments; combinational logic above uses blocking.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            sclk_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            sclk_q  <= sclk_d;
        end
    end

    assign sclk_o = sclk_q;

endmodule

// File: rtl/distribution_store_unit.sv
// Serialises {opcode, address, 256-bit distribution word} onto an SPI mode-0 link
// and stalls the core clock while the frame is in flight.
module distribution_store_unit
    import distribution_store_unit_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         DSCtrl,
    input  logic [31:0]  rs1,
    input  logic [255:0] DS_input,
    output logic         spi_sclk,
    output logic         spi_mosi,
    output logic         spi_cs_n,
    output logic         ds_clk_stall,
    output logic         ds_done
);

    localparam logic [8:0] LAST_BIT = 9'(FRAME_BITS - 1);

    ds_state_e             state_q, state_d;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic [8:0]            bit_cnt_q, bit_cnt_d;

    logic gen_en, gen_hold, half_tick, sclk_rise, sclk_fall;

    assign gen_en   = (state_q == ST_SETUP) || (state_q == ST_SHIFT);
    assign gen_hold = (state_q == ST_SETUP);

    spi_sclk_gen #(
        .HALF_PERIOD (HALF_PERIOD)
    ) u_sclk_gen (
        .clk         (clk),
        .reset       (reset),
        .en_i        (gen_en),
        .hold_i      (gen_hold),
        .sclk_o      (spi_sclk),
        .half_tick_o (half_tick),
        .rise_o      (sclk_rise),
        .fall_o      (sclk_fall)
    );

    // Address bits [31:24] are not part of the frame; the rise strobe is not needed here.
    logic unused_bits;
    assign unused_bits = ^{rs1[31:24], sclk_rise};

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        spi_cs_n     = 1'b1;
        spi_mosi     = 1'b0;
        ds_clk_stall = 1'b1;
        ds_done      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ds_clk_stall = 1'b0;
                if (DSCtrl) begin
                    shreg_d   = build_frame(rs1[ADDR_BITS-1:0], DS_input);
                    bit_cnt_d = '0;
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                spi_cs_n = 1'b0;
                spi_mosi = shreg_q[FRAME_BITS-1];
                if (half_tick) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                spi_cs_n = 1'b0;
                spi_mosi = shreg_q[FRAME_BITS-1];
                // Data advances on the falling edge so it is stable at the receiver's rising edge.
                if (sclk_fall) begin
                    shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = ST_DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 9'd1;
                    end
                end
            end
            ST_DONE: begin
                ds_done = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                ds_clk_stall = 1'b0;
                state_d      = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // NOTE: the frame register has no reset; it is loaded on capture and only observed in SETUP/SHIFT.
    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

endmodule

// File: tb/tb_distribution_store_unit.sv
// Directed bench for distribution_store_unit: two instances (HALF_PERIOD 1 and 3)
// share stimulus; an SPI receiver task captures mosi on each sclk rise.
module tb_distribution_store_unit;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         DSCtrl = 1'b0;
    logic [31:0]  rs1 = '0;
    logic [255:0] DS_input = '0;

    logic a_sclk, a_mosi, a_cs_n, a_stall, a_done;
    logic b_sclk, b_mosi, b_cs_n, b_stall, b_done;

    int n_checks = 0;
    int n_fail   = 0;
    int sel      = 0;

    always #5 clk = ~clk;

    distribution_store_unit #(.HALF_PERIOD(1)) dut_h1 (
        .clk          (clk),
        .reset        (reset),
        .DSCtrl       (DSCtrl),
        .rs1          (rs1),
        .DS_input     (DS_input),
        .spi_sclk     (a_sclk),
        .spi_mosi     (a_mosi),
        .spi_cs_n     (a_cs_n),
        .ds_clk_stall (a_stall),
        .ds_done      (a_done)
    );

    distribution_store_unit #(.HALF_PERIOD(3)) dut_h3 (
        .clk          (clk),
        .reset        (reset),
        .DSCtrl       (DSCtrl),
        .rs1          (rs1),
        .DS_input     (DS_input),
        .spi_sclk     (b_sclk),
        .spi_mosi     (b_mosi),
        .spi_cs_n     (b_cs_n),
        .ds_clk_stall (b_stall),
        .ds_done      (b_done)
    );

    wire m_sclk  = (sel == 0) ? a_sclk  : b_sclk;
    wire m_mosi  = (sel == 0) ? a_mosi  : b_mosi;
    wire m_cs_n  = (sel == 0) ? a_cs_n  : b_cs_n;
    wire m_stall = (sel == 0) ? a_stall : b_stall;
    wire m_done  = (sel == 0) ? a_done  : b_done;

    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b1;
        DSCtrl = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Caller raises DSCtrl at a negedge, then calls this. Observes one frame of the
    // selected instance until ds_clk_stall drops. inject_kind: 0 none, 1 DSCtrl pulse
    // with alt_data, 2 assert reset and return, both when inject_at bits have been received.
    task automatic capture(input int which, input bit hold, input int inject_kind,
                           input int inject_at, input logic [255:0] alt_data, input int budget,
                           output logic [287:0] bits, output int nbits, output int stall,
                           output int dones, output int period, output int tail_cs_high,
                           output logic first_cs_n, output bit timeout);
        int   cyc = 0;
        int   r0 = -1;
        logic prev = 1'b0;
        bit   saw = 1'b0;
        bit   fin = 1'b0;
        bit   release_ctrl = 1'b0;
        bits = '0; nbits = 0; stall = 0; dones = 0; period = -1;
        tail_cs_high = 0; first_cs_n = 1'bx; timeout = 1'b0;
        sel = which;
        while (!fin) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) first_cs_n = m_cs_n;
            if (m_stall === 1'b1) begin stall++; saw = 1'b1; end
            if (m_done === 1'b1) dones++;
            if (m_cs_n === 1'b1) tail_cs_high++; else tail_cs_high = 0;
            if (release_ctrl) begin DSCtrl = 1'b0; release_ctrl = 1'b0; end
            if (cyc == 1 && !hold) DSCtrl = 1'b0;
            if (m_sclk === 1'b1 && prev === 1'b0) begin
                bits = {bits[286:0], m_mosi};
                if (nbits == 0) r0 = cyc;
                else if (nbits == 1) period = cyc - r0;
                nbits++;
                if (inject_kind == 1 && nbits == inject_at) begin
                    DSCtrl = 1'b1;
                    DS_input = alt_data;
                    release_ctrl = 1'b1;
                end
            end
            prev = m_sclk;
            if (inject_kind == 2 && nbits == inject_at) begin
                reset = 1'b1;
                fin = 1'b1;
            end else if (saw && m_stall === 1'b0) begin
                fin = 1'b1;
            end else if (cyc >= budget) begin
                timeout = 1'b1;
                fin = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; DSCtrl = 1'b1; rs1 = 32'h0000_00AA; DS_input = '1;
        repeat (2) @(negedge clk);
        n_checks++; if (a_cs_n !== 1'b1)  begin n_fail++; $display("FAIL reset_cs_n: got %b want 1", a_cs_n); end
        n_checks++; if (a_sclk !== 1'b0)  begin n_fail++; $display("FAIL reset_sclk: got %b want 0", a_sclk); end
        n_checks++; if (a_mosi !== 1'b0)  begin n_fail++; $display("FAIL reset_mosi: got %b want 0", a_mosi); end
        n_checks++; if (a_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", a_stall); end
        n_checks++; if (a_done !== 1'b0)  begin n_fail++; $display("FAIL reset_done: got %b want 0", a_done); end
        n_checks++; if (b_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall_h3: got %b want 0", b_stall); end
        reset = 1'b0; DSCtrl = 1'b0;
        @(negedge clk);
        n_checks++; if (a_stall !== 1'b0) begin n_fail++; $display("FAIL reset_priority: got stall %b want 0", a_stall); end
    endtask

    task automatic test_basic_frame();
        logic [287:0] bits, exp; int nb, st, dn, per, tail; logic fcs; bit to;
        do_reset();
        rs1 = 32'hFF00_1234; DS_input = 256'h1;
        exp = {8'h02, 24'h001234, 256'h1};
        DSCtrl = 1'b1;
        capture(0, 1'b0, 0, 0, '0, 2000, bits, nb, st, dn, per, tail, fcs, to);
        n_checks++; if (to)          begin n_fail++; $display("FAIL basic_timeout: frame did not finish"); end
        n_checks++; if (nb !== 288)  begin n_fail++; $display("FAIL basic_nbits: got %0d want 288", nb); end
        n_checks++; if (bits !== exp) begin n_fail++; $display("FAIL basic_data: got %h want %h", bits, exp); end
        n_checks++; if (st !== 578)  begin n_fail++; $display("FAIL basic_stall: got %0d want 578", st); end
        n_checks++; if (dn !== 1)    begin n_fail++; $display("FAIL basic_done: got %0d want 1", dn); end
        n_checks++; if (per !== 2)   begin n_fail++; $display("FAIL basic_period: got %0d want 2", per); end
        n_checks++; if (fcs !== 1'b0) begin n_fail++; $display("FAIL basic_cs_first: got %b want 0", fcs); end
        n_checks++; if (a_cs_n !== 1'b1 || a_sclk !== 1'b0 || a_mosi !== 1'b0)
            begin n_fail++; $display("FAIL basic_idle_outs: got cs_n %b sclk %b mosi %b want 1 0 0", a_cs_n, a_sclk, a_mosi); end
    endtask

    task automatic test_half_period3();
        logic [287:0] bits; int nb, st, dn, per, tail; logic fcs; bit to;
        logic [255:0] ones;
        ones = '1;
        do_reset();
        rs1 = 32'h1234_5678; DS_input = ones;
        DSCtrl = 1'b1;
        capture(1, 1'b0, 0, 0, '0, 4000, bits, nb, st, dn, per, tail, fcs, to);
        n_checks++; if (to)          begin n_fail++; $display("FAIL hp3_timeout: frame did not finish"); end
        n_checks++; if (nb !== 288)  begin n_fail++; $display("FAIL hp3_nbits: got %0d want 288", nb); end
        n_checks++; if (bits[287:256] !== 32'h0234_5678) begin n_fail++; $display("FAIL hp3_header: got %h want 02345678", bits[287:256]); end
        n_checks++; if (bits[255:0] !== ones) begin n_fail++; $display("FAIL hp3_data: got %h want all ones", bits[255:0]); end
        n_checks++; if (st !== 1732) begin n_fail++; $display("FAIL hp3_stall: got %0d want 1732", st); end
        n_checks++; if (per !== 6)   begin n_fail++; $display("FAIL hp3_period: got %0d want 6", per); end
        n_checks++; if (dn !== 1)    begin n_fail++; $display("FAIL hp3_done: got %0d want 1", dn); end
    endtask

    task automatic test_ignore_dsctrl();
        logic [287:0] bits, exp; int nb, st, dn, per, tail; logic fcs; bit to;
        logic [255:0] data_a;
        bit extra = 1'b0;
        data_a = {8{32'hC0DE_5A5A}};
        do_reset();
        rs1 = 32'h00AB_CDEF; DS_input = data_a;
        exp = {8'h02, 24'hABCDEF, data_a};
        DSCtrl = 1'b1;
        capture(0, 1'b0, 1, 100, ~data_a, 2000, bits, nb, st, dn, per, tail, fcs, to);
        n_checks++; if (to)           begin n_fail++; $display("FAIL ign_timeout: frame did not finish"); end
        n_checks++; if (bits !== exp) begin n_fail++; $display("FAIL ign_data: got %h want %h", bits, exp); end
        n_checks++; if (dn !== 1)     begin n_fail++; $display("FAIL ign_done: got %0d want 1", dn); end
        n_checks++; if (st !== 578)   begin n_fail++; $display("FAIL ign_stall: got %0d want 578", st); end
        repeat (10) begin
            @(negedge clk);
            if (a_stall !== 1'b0) extra = 1'b1;
        end
        n_checks++; if (extra) begin n_fail++; $display("FAIL ign_queued: got new frame want idle"); end
    endtask

    task automatic test_reset_abort();
        logic [287:0] bits, exp; int nb, st, dn, per, tail; logic fcs; bit to;
        logic [255:0] data_b;
        data_b = {4{64'h0123_4567_89AB_CDEF}};
        do_reset();
        rs1 = 32'h0000_0001; DS_input = ~data_b;
        DSCtrl = 1'b1;
        capture(0, 1'b0, 2, 150, '0, 2000, bits, nb, st, dn, per, tail, fcs, to);
        n_checks++; if (nb !== 150) begin n_fail++; $display("FAIL abort_reach: got %0d bits want 150", nb); end
        @(posedge clk); #1;
        n_checks++; if (a_cs_n !== 1'b1)  begin n_fail++; $display("FAIL abort_cs_n: got %b want 1", a_cs_n); end
        n_checks++; if (a_sclk !== 1'b0)  begin n_fail++; $display("FAIL abort_sclk: got %b want 0", a_sclk); end
        n_checks++; if (a_stall !== 1'b0) begin n_fail++; $display("FAIL abort_stall: got %b want 0", a_stall); end
        n_checks++; if (a_done !== 1'b0 || dn !== 0) begin n_fail++; $display("FAIL abort_done: got %b/%0d want 0/0", a_done, dn); end
        @(negedge clk);
        reset = 1'b0;
        rs1 = 32'h5500_0F0F; DS_input = data_b;
        exp = {8'h02, 24'h000F0F, data_b};
        DSCtrl = 1'b1;
        capture(0, 1'b0, 0, 0, '0, 2000, bits, nb, st, dn, per, tail, fcs, to);
        n_checks++; if (bits !== exp) begin n_fail++; $display("FAIL abort_refrm_data: got %h want %h", bits, exp); end
        n_checks++; if (dn !== 1)     begin n_fail++; $display("FAIL abort_refrm_done: got %0d want 1", dn); end
        n_checks++; if (st !== 578)   begin n_fail++; $display("FAIL abort_refrm_stall: got %0d want 578", st); end
    endtask

    task automatic test_back_to_back();
        logic [287:0] bits, exp; int nb, st, dn, per, tail; logic fcs; bit to;
        logic [255:0] data_c;
        bit extra = 1'b0;
        data_c = {16{16'hF00D}};
        do_reset();
        rs1 = 32'h0012_3456; DS_input = data_c;
        exp = {8'h02, 24'h123456, data_c};
        DSCtrl = 1'b1;
        capture(0, 1'b1, 0, 0, '0, 2000, bits, nb, st, dn, per, tail, fcs, to);
        n_checks++; if (bits !== exp) begin n_fail++; $display("FAIL b2b_f1_data: got %h want %h", bits, exp); end
        n_checks++; if (dn !== 1)     begin n_fail++; $display("FAIL b2b_f1_done: got %0d want 1", dn); end
        n_checks++; if (st !== 578)   begin n_fail++; $display("FAIL b2b_f1_stall: got %0d want 578", st); end
        n_checks++; if (tail !== 2)   begin n_fail++; $display("FAIL b2b_gap: got %0d cs_n-high cycles want 2", tail); end
        capture(0, 1'b0, 0, 0, '0, 2000, bits, nb, st, dn, per, tail, fcs, to);
        n_checks++; if (fcs !== 1'b0) begin n_fail++; $display("FAIL b2b_f2_start: got cs_n %b want 0", fcs); end
        n_checks++; if (bits !== exp) begin n_fail++; $display("FAIL b2b_f2_data: got %h want %h", bits, exp); end
        n_checks++; if (dn !== 1)     begin n_fail++; $display("FAIL b2b_f2_done: got %0d want 1", dn); end
        n_checks++; if (st !== 578)   begin n_fail++; $display("FAIL b2b_f2_stall: got %0d want 578", st); end
        repeat (10) begin
            @(negedge clk);
            if (a_stall !== 1'b0) extra = 1'b1;
        end
        n_checks++; if (extra) begin n_fail++; $display("FAIL b2b_third: got extra frame want idle"); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_half_period3();
        test_ignore_dsctrl();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
